// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests, buffers a word across decode stalls,
// and squashes or drops in-flight fetches when a redirect arrives.
module fetch_unit #(
  parameter int                 PC_BITS  = 32,
  parameter int                 IR_BITS  = 32,
  parameter logic [PC_BITS-1:0] RESET_PC = PC_BITS'(32'h0000_3000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               redirect_valid,
  input  logic [PC_BITS-1:0] redirect_pc,
  output logic               imem_req,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [IR_BITS-1:0] imem_rdata,
  output logic               if_id_load,
  output logic               if_id_zero,
  output logic [PC_BITS-1:0] pc_out,
  output logic [IR_BITS-1:0] ir_out
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] addr_hold_q, addr_hold_d;
  logic [IR_BITS-1:0] ir_buf_q, ir_buf_d;
  logic [PC_BITS-1:0] redirect_aligned;
  logic [PC_BITS-1:0] pc_next;

  assign redirect_aligned = redirect_pc & ~PC_BITS'(3);
  assign pc_next          = pc_q + PC_BITS'(4);
  assign pc_out           = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_hold_d = addr_hold_q;
    ir_buf_d    = ir_buf_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    if_id_load  = 1'b0;
    if_id_zero  = 1'b0;
    ir_out      = ir_buf_q;

    // DROP keeps presenting the abandoned address so the memory handshake stays stable
    if (state_q == FETCH) begin
      imem_req = 1'b1;
    end else if (state_q == DROP) begin
      imem_req  = 1'b1;
      imem_addr = addr_hold_q;
    end

    if (redirect_valid) begin
      if_id_zero = !rst;
      pc_d       = redirect_aligned;
      ir_buf_d   = '0;
      case (state_q)
        FETCH: begin
          if (!imem_ack) begin
            addr_hold_d = pc_q;
            state_d     = DROP;
          end
        end
        // An ack arriving alongside the redirect retires the abandoned request
        DROP:    state_d = imem_ack ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (imem_ack && !stall_in) begin
            if_id_load = 1'b1;
            ir_out     = imem_rdata;
            pc_d       = pc_next;
          end else if (imem_ack) begin
            ir_buf_d = imem_rdata;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            if_id_load = 1'b1;
            pc_d       = pc_next;
            state_d    = FETCH;
          end
        end
        default: begin
          if (imem_ack) state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      addr_hold_q <= '0;
      ir_buf_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_hold_q <= addr_hold_d;
      ir_buf_q    <= ir_buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a vector table drives each cycle, and delivered
// instructions are matched against a queue of expected {pc, ir} pairs.
module tb_fetch_unit;

  typedef struct {
    string       name;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_load;
    logic        exp_zero;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_load;
  logic        if_id_zero;
  logic [31:0] pc_out;
  logic [31:0] ir_out;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_load(if_id_load), .if_id_zero(if_id_zero),
    .pc_out(pc_out), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic stall, logic redir, logic [31:0] rpc,
                              logic ack, logic [31:0] rdata, logic exp_req,
                              logic [31:0] exp_addr, logic exp_load, logic exp_zero,
                              logic [31:0] exp_pc, logic [31:0] exp_ir);
    vec_t v;
    v.name = name; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.ack = ack; v.rdata = rdata; v.exp_req = exp_req; v.exp_addr = exp_addr;
    v.exp_load = exp_load; v.exp_zero = exp_zero; v.exp_pc = exp_pc; v.exp_ir = exp_ir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    stall_in       = v.stall;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    imem_ack       = v.ack;
    imem_rdata     = v.rdata;
    if (v.exp_load) begin
      e.pc = v.exp_pc;
      e.ir = v.exp_ir;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    sb_t e;
    check({v.name, " req"}, {31'd0, imem_req}, {31'd0, v.exp_req});
    if (v.exp_req) check({v.name, " addr"}, imem_addr, v.exp_addr);
    check({v.name, " load"}, {31'd0, if_id_load}, {31'd0, v.exp_load});
    check({v.name, " zero"}, {31'd0, if_id_zero}, {31'd0, v.exp_zero});
    if (if_id_load) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL %s unexpected load: pc_out %h, no delivery expected", v.name, pc_out);
      end else begin
        e = sb.pop_front();
        check({v.name, " pc_out"}, pc_out, e.pc);
        check({v.name, " ir_out"}, ir_out, e.ir);
      end
    end
  endtask

  initial begin
    // name, stall, redir, rpc, ack, rdata, req, addr, load, zero, pc, ir
    vecs.push_back(mk("boot",        0,0,32'h0,        1,32'h0,        0,32'h0,        0,0,32'h0,        32'h0));
    vecs.push_back(mk("f3000",       0,0,32'h0,        1,32'h3000,     1,32'h3000,     1,0,32'h3000,     32'h3000));
    vecs.push_back(mk("f3004",       0,0,32'h0,        1,32'h3004,     1,32'h3004,     1,0,32'h3004,     32'h3004));
    vecs.push_back(mk("stall_ack",   1,0,32'h0,        1,32'h3008,     1,32'h3008,     0,0,32'h0,        32'h0));
    vecs.push_back(mk("hold1",       1,0,32'h0,        1,32'h0,        0,32'h0,        0,0,32'h0,        32'h0));
    vecs.push_back(mk("hold2",       1,0,32'h0,        1,32'h0,        0,32'h0,        0,0,32'h0,        32'h0));
    vecs.push_back(mk("hold_rel",    0,0,32'h0,        1,32'h0,        0,32'h0,        1,0,32'h3008,     32'h3008));
    vecs.push_back(mk("f300c",       0,0,32'h0,        1,32'h300C,     1,32'h300C,     1,0,32'h300C,     32'h300C));
    vecs.push_back(mk("wait_redir",  0,1,32'h4002,     0,32'h0,        1,32'h3010,     0,1,32'h0,        32'h0));
    vecs.push_back(mk("drop_wait",   0,0,32'h0,        0,32'h0,        1,32'h3010,     0,0,32'h0,        32'h0));
    vecs.push_back(mk("drop_ack",    0,0,32'h0,        1,32'hDEAD,     1,32'h3010,     0,0,32'h0,        32'h0));
    vecs.push_back(mk("f4000",       0,0,32'h0,        1,32'h4000,     1,32'h4000,     1,0,32'h4000,     32'h4000));
    vecs.push_back(mk("redir_stall", 1,1,32'h5000,     1,32'hBAD0,     1,32'h4004,     0,1,32'h0,        32'h0));
    vecs.push_back(mk("f5000_wait",  0,0,32'h0,        0,32'h0,        1,32'h5000,     0,0,32'h0,        32'h0));
    vecs.push_back(mk("f5000",       0,0,32'h0,        1,32'h5000,     1,32'h5000,     1,0,32'h5000,     32'h5000));
    vecs.push_back(mk("redir_top",   0,1,32'hFFFFFFFC, 1,32'hBAD1,     1,32'h5004,     0,1,32'h0,        32'h0));
    vecs.push_back(mk("f_top",       0,0,32'h0,        1,32'hFFFFFFFC, 1,32'hFFFFFFFC, 1,0,32'hFFFFFFFC, 32'hFFFFFFFC));
    vecs.push_back(mk("f_wrap",      0,0,32'h0,        1,32'h1234,     1,32'h0,        1,0,32'h0,        32'h1234));
    vecs.push_back(mk("stall_4",     1,0,32'h0,        1,32'hABCD,     1,32'h4,        0,0,32'h0,        32'h0));
    vecs.push_back(mk("hold_redir",  1,1,32'h6000,     0,32'h0,        0,32'h0,        0,1,32'h0,        32'h0));
    vecs.push_back(mk("to_drop",     0,1,32'h7001,     0,32'h0,        1,32'h6000,     0,1,32'h0,        32'h0));

    rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h9000;
    imem_ack = 1'b1; imem_rdata = 32'h0;
    #2;
    check("rst req",  {31'd0, imem_req},   32'd0);
    check("rst load", {31'd0, if_id_load}, 32'd0);
    check("rst zero", {31'd0, if_id_zero}, 32'd0);
    check("rst pc",   pc_out, 32'h3000);
    check("rst ir",   ir_out, 32'h0);
    @(negedge clk);
    check("rst pc after edge", pc_out, 32'h3000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i]);
      @(negedge clk);
    end

    // Reset pulse between edges while a dropped request is still outstanding
    applyStimulus(mk("drop_pre_rst", 0,0,32'h0, 0,32'h0, 1,32'h6000, 0,0,32'h0, 32'h0));
    #1;
    checkOutput(mk("drop_pre_rst", 0,0,32'h0, 0,32'h0, 1,32'h6000, 0,0,32'h0, 32'h0));
    #2 rst = 1'b1;
    #1;
    check("midrst req",  {31'd0, imem_req},   32'd0);
    check("midrst load", {31'd0, if_id_load}, 32'd0);
    check("midrst zero", {31'd0, if_id_zero}, 32'd0);
    check("midrst pc",   pc_out, 32'h3000);
    check("midrst ir",   ir_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk("boot_late_ack", 0,0,32'h0, 1,32'hBAD2, 0,32'h0, 0,0,32'h0, 32'h0));
    #1;
    checkOutput(mk("boot_late_ack", 0,0,32'h0, 1,32'hBAD2, 0,32'h0, 0,0,32'h0, 32'h0));
    @(negedge clk);
    applyStimulus(mk("restart", 0,0,32'h0, 1,32'h3000, 1,32'h3000, 1,0,32'h3000, 32'h3000));
    #1;
    checkOutput(mk("restart", 0,0,32'h0, 1,32'h3000, 1,32'h3000, 1,0,32'h3000, 32'h3000));
    @(negedge clk);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
